fir_decim_filter: RTL and testbench
===================================

Name: fir_decim_filter

Overview:
Parametrised successor to the fixed 16-bit FIR stage in the FMCW receive chain: a decimating FIR filter with runtime-loadable coefficients and a single time-shared MAC. It takes mixer output samples on a strobe and keeps the last NUM_TAPS samples in a circular delay line. Every DECIM-th accepted sample it produces one rounded, saturated output. Output feeds the range-FFT buffer.

Parameters:
DATA_W, 16, signed input sample width
COEF_W, 16, signed coefficient width
NUM_TAPS, 32, tap count (>=2; need not be a power of 2)
DECIM, 4, decimation factor (>=1)
SHIFT, 12, arithmetic right shift applied to the accumulator before output
OUT_W, 28, signed output width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ready  in  1  input sample strobe; mix_data is valid this cycle
mix_data  in  DATA_W  signed input sample
in_ready  out  1  high when a strobe will be accepted
flush  in  1  synchronous clear of delay line, phase counter and overflow flag
coef_we  in  1  coefficient write strobe
coef_addr  in  $clog2(NUM_TAPS)  tap index
coef_data  in  COEF_W  signed coefficient
coef_err  out  1  one-cycle pulse: coefficient write rejected
fir_data  out  OUT_W  signed filtered output
valid  out  1  one-cycle pulse; fir_data is valid this cycle
overflow  out  1  sticky: an input strobe was dropped

Behaviour:
- Clocking and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - fir_data=0, valid=0, coef_err=0, overflow=0, in_ready=1.
  - Delay line all 0; write pointer 0; phase counter 0; state IDLE.
  - Coefficients: c[0]=2^SHIFT, all others 0. The filter powers up as a decimated pass-through.
- Reset mid-computation aborts the computation. No valid is issued.
- Accumulator width: ACC_W = DATA_W+COEF_W+$clog2(NUM_TAPS). Full-precision signed products and sums; the accumulator never wraps.
- FSM states:
  - IDLE: in_ready=1. A ready strobe writes mix_data at the write pointer (wraps NUM_TAPS-1 -> 0) and advances the phase counter.
    - If phase was DECIM-1, phase returns to 0 and the state goes to MAC.
    - Otherwise the state stays IDLE.
  - MAC: in_ready=0. Runs NUM_TAPS cycles with registered read. Accumulates acc += c[k]*x[n-k] for k=0..NUM_TAPS-1, where x[n] is the sample just written.
  - OUT: one cycle of round and saturate, then back to IDLE. valid and fir_data are registered.
- Latency: when the DECIM-th sample is accepted at edge T, valid is high for exactly the cycle after edge T+NUM_TAPS+2.
  - in_ready returns high in that same cycle.
  - A strobe in that cycle is accepted.
- Rounding and saturation:
  - y = (acc + 2^(SHIFT-1)) >>> SHIFT, i.e. round half toward +inf. SHIFT=0 means no rounding.
  - y is then saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Dropped input: a strobe while in_ready=0 is dropped. Delay line and phase are unchanged, and overflow is set (cleared only by flush or reset).
- Flush (acts in any state):
  - Zeroes the delay line, pointer, phase and overflow, and returns to IDLE without a valid.
  - Coefficients are kept.
  - flush together with ready: flush wins and the sample is discarded without setting overflow.
- Coefficient writes:
  - Accepted only in IDLE with coef_addr<NUM_TAPS; the new value is visible to the next MAC.
  - Rejected and coef_err pulsed the next cycle when coef_we is high in MAC or OUT, or when coef_addr>=NUM_TAPS. The coefficient is unchanged.
  - coef_we together with ready in IDLE: both are performed. If this sample triggers MAC, the new coefficient is used.
- Sample rate: sustained throughput requires a strobe spacing of at least NUM_TAPS+3 cycles per output group. Faster strobes are dropped as above.

Decomposition:
- Shared FMCW filter package/header holds:
  - ACC_W derivation function.
  - FSM state encoding (IDLE/MAC/OUT).
  - Round-half-up and saturate helper constants.
- One sub-module: fir_round_sat (ACC_W, SHIFT, OUT_W). It is purely combinational round and saturate, instantiated before the output register and unit-tested on its own.

Test Plan:
- Defaults (DECIM=4, c[0]=4096, SHIFT=12), ramp 1..8 strobed every 40 cycles -> two valid pulses, fir_data=4 then 8. Each valid comes 34 edges after the 4th/8th strobe.
- NUM_TAPS=8, DECIM=1; write c[k]=k*4096; impulse 100 followed by zeros, every 12 cycles -> fir_data sequence 0,100,200,...,700 then 0.
- Rounding, SHIFT=12, c[0]=2048: x=3 -> 2; x=-3 -> -1; x=1 -> 1; x=-1 -> 0.
- Saturation, SHIFT=0, all 32 coefs 32767: x=32767 held 32 samples -> 134217727; all coefs 32767 with x=-32768 -> -134217728.
- Strobe 5 cycles after the 4th sample (in MAC) -> overflow=1, sample ignored, next output unchanged. Then flush -> overflow=0, and the next output uses an all-zero history.
- coef_we during MAC -> coef_err pulse, coefficient unchanged. coef_addr=40 with NUM_TAPS=32 in IDLE -> coef_err pulse. rst_n low mid-MAC -> no valid, coefficients back to reset values.

Source files
------------

// File: rtl/fir_decim_filter_pkg.sv
// Shared FMCW filter definitions: accumulator sizing, FSM encoding, round/saturate helpers.
// Pure declarations, no timing or flow control of its own.
package fir_decim_filter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } fir_state_t;

  // Full-precision accumulator: one product plus log2(taps) bits of sum growth.
  function automatic int fir_acc_w(input int data_w, input int coef_w, input int num_taps);
    return data_w + coef_w + $clog2(num_taps);
  endfunction

  // Bit position of the half-LSB bias added before the shift (unused when shift == 0).
  function automatic int round_pos(input int shift);
    return (shift > 0) ? shift - 1 : 0;
  endfunction

  // Width wide enough to hold both the shifted accumulator and the output limits.
  function automatic int sat_w(input int acc_w, input int out_w);
    return (acc_w + 1 > out_w) ? acc_w + 1 : out_w;
  endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Round-half-up arithmetic right shift followed by saturation to OUT_W signed.
// Combinational, zero latency; no flow control.
module fir_round_sat
  import fir_decim_filter_pkg::*;
#(
  parameter int ACC_W = 37,
  parameter int SHIFT = 12,
  parameter int OUT_W = 28
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic signed [OUT_W-1:0] y
);

  localparam int SW = sat_w(ACC_W, OUT_W);
  localparam logic signed [ACC_W:0] BIAS =
    (SHIFT > 0) ? ((ACC_W+1)'(1) << round_pos(SHIFT)) : '0;
  localparam logic signed [SW-1:0] SAT_MAX = (SW'(1) << (OUT_W - 1)) - SW'(1);
  localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

  logic signed [ACC_W:0] biased;
  logic signed [ACC_W:0] shifted;
  logic signed [SW-1:0]  wide;

  // One extra bit so the bias can never wrap a near-full-scale accumulator.
  always_comb begin
    biased  = {acc[ACC_W-1], acc} + BIAS;
    shifted = biased >>> SHIFT;
    wide    = SW'(shifted);
    if (wide > SAT_MAX) begin
      y = SAT_MAX[OUT_W-1:0];
    end else if (wide < SAT_MIN) begin
      y = SAT_MIN[OUT_W-1:0];
    end else begin
      y = wide[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/fir_decim_filter.sv
// Decimating FIR with runtime coefficients and one time-shared MAC.
// Output NUM_TAPS+2 cycles after every DECIM-th sample; strobes outside IDLE are dropped and flagged.
module fir_decim_filter
  import fir_decim_filter_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int COEF_W   = 16,
  parameter int NUM_TAPS = 32,
  parameter int DECIM    = 4,
  parameter int SHIFT    = 12,
  parameter int OUT_W    = 28
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ready,
  input  logic signed [DATA_W-1:0]    mix_data,
  output logic                        in_ready,
  input  logic                        flush,
  input  logic                        coef_we,
  input  logic [$clog2(NUM_TAPS)-1:0] coef_addr,
  input  logic signed [COEF_W-1:0]    coef_data,
  output logic                        coef_err,
  output logic signed [OUT_W-1:0]     fir_data,
  output logic                        valid,
  output logic                        overflow
);

  localparam int ACC_W  = fir_acc_w(DATA_W, COEF_W, NUM_TAPS);
  localparam int AW     = $clog2(NUM_TAPS);
  localparam int PW     = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int CW     = $clog2(NUM_TAPS + 1);
  localparam int PROD_W = DATA_W + COEF_W;

  localparam logic [AW-1:0]         LAST_IDX = AW'(NUM_TAPS - 1);
  localparam logic [PW-1:0]         LAST_PH  = PW'(DECIM - 1);
  localparam logic [CW-1:0]         MAC_END  = CW'(NUM_TAPS);
  localparam logic signed [COEF_W-1:0] C0_RST = COEF_W'(1) << SHIFT;

  fir_state_t state, state_nxt;

  logic signed [DATA_W-1:0] dline [NUM_TAPS];
  logic signed [COEF_W-1:0] coef  [NUM_TAPS];
  logic [AW-1:0]            wptr;
  logic [AW-1:0]            rd_idx;
  logic [PW-1:0]            phase;
  logic [CW-1:0]            mac_cnt;
  logic signed [DATA_W-1:0] op_x;
  logic signed [COEF_W-1:0] op_c;
  logic                     op_vld;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc;
  logic signed [OUT_W-1:0]  y_rs;
  logic                     accept;
  logic                     drop;
  logic                     last_phase;
  logic                     start_mac;
  logic                     mac_rd;
  logic                     coef_ok;

  // Flush outranks a coincident strobe: the sample vanishes without counting as a drop.
  assign accept     = ready && !flush && (state == ST_IDLE);
  assign drop       = ready && !flush && (state != ST_IDLE);
  assign last_phase = (phase == LAST_PH);
  assign start_mac  = accept && last_phase;
  assign coef_ok    = coef_we && (state == ST_IDLE) && (int'(coef_addr) < NUM_TAPS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (start_mac) state_nxt = ST_MAC;
        ST_MAC:  if (mac_cnt == MAC_END) state_nxt = ST_OUT;
        ST_OUT:  state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready = (state == ST_IDLE);
    mac_rd   = (state == ST_MAC) && (mac_cnt != MAC_END);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_TAPS; i++) dline[i] <= '0;
      wptr     <= '0;
      phase    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      for (int i = 0; i < NUM_TAPS; i++) dline[i] <= '0;
      wptr     <= '0;
      phase    <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) begin
        dline[wptr] <= mix_data;
        wptr        <= (wptr == LAST_IDX) ? '0 : wptr + 1'b1;
        phase       <= last_phase ? '0 : phase + 1'b1;
      end
      if (drop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_TAPS; i++) coef[i] <= '0;
      coef[0]  <= C0_RST;
      coef_err <= 1'b0;
    end else begin
      if (coef_ok) coef[coef_addr] <= coef_data;
      coef_err <= coef_we && !coef_ok;
    end
  end

  assign prod = PROD_W'(op_x) * PROD_W'(op_c);

  // Walk backwards from the sample just written; operands are registered, so the
  // last product lands in the accumulator one cycle after the final read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mac_cnt <= '0;
      rd_idx  <= '0;
      op_x    <= '0;
      op_c    <= '0;
      op_vld  <= 1'b0;
      acc     <= '0;
    end else if (flush) begin
      mac_cnt <= '0;
      op_vld  <= 1'b0;
    end else begin
      op_vld <= 1'b0;
      if (start_mac) begin
        mac_cnt <= '0;
        rd_idx  <= wptr;
        acc     <= '0;
      end else if (mac_rd) begin
        op_x    <= dline[rd_idx];
        op_c    <= coef[mac_cnt[AW-1:0]];
        op_vld  <= 1'b1;
        rd_idx  <= (rd_idx == '0) ? LAST_IDX : rd_idx - 1'b1;
        mac_cnt <= mac_cnt + 1'b1;
      end
      if (op_vld) acc <= acc + ACC_W'(prod);
    end
  end

  fir_round_sat #(
    .ACC_W(ACC_W),
    .SHIFT(SHIFT),
    .OUT_W(OUT_W)
  ) u_round_sat (
    .acc(acc),
    .y  (y_rs)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fir_data <= '0;
      valid    <= 1'b0;
    end else begin
      valid <= (state == ST_OUT) && !flush;
      if ((state == ST_OUT) && !flush) fir_data <= y_rs;
    end
  end

endmodule

// File: tb/tb_fir_decim_filter.sv
// Scoreboard bench for fir_decim_filter across four parameterisations sharing one stimulus bus.
module tb_fir_decim_filter;

  localparam int SMAX = 134217727;
  localparam int SMIN = -134217728;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [1:0]         sel = 2'd0;
  logic               ready = 1'b0;
  logic               flush = 1'b0;
  logic               coef_we = 1'b0;
  logic signed [15:0] mix_data = '0;
  logic signed [15:0] coef_data = '0;
  logic [5:0]         coef_addr = '0;

  logic [3:0]         v, ir, ce, ov;
  logic signed [27:0] fd [4];

  typedef struct {
    int inst;
    int data;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   ntaps   [4] = '{32, 8, 32, 20};
  int   rnd_x   [4] = '{3, -3, 1, -1};
  int   rnd_y   [4] = '{2, -1, 1, 0};
  int   neg_exp [8] = '{SMAX, SMAX, SMAX, -524272, SMIN, SMIN, SMIN, SMIN};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fir_decim_filter #(.DATA_W(16), .COEF_W(16), .NUM_TAPS(32), .DECIM(4), .SHIFT(12), .OUT_W(28)) u0 (
    .clk(clk), .rst_n(rst_n), .ready(ready && sel == 2'd0), .mix_data(mix_data), .in_ready(ir[0]),
    .flush(flush && sel == 2'd0), .coef_we(coef_we && sel == 2'd0), .coef_addr(coef_addr[4:0]),
    .coef_data(coef_data), .coef_err(ce[0]), .fir_data(fd[0]), .valid(v[0]), .overflow(ov[0]));

  fir_decim_filter #(.DATA_W(16), .COEF_W(16), .NUM_TAPS(8), .DECIM(1), .SHIFT(12), .OUT_W(28)) u1 (
    .clk(clk), .rst_n(rst_n), .ready(ready && sel == 2'd1), .mix_data(mix_data), .in_ready(ir[1]),
    .flush(flush && sel == 2'd1), .coef_we(coef_we && sel == 2'd1), .coef_addr(coef_addr[2:0]),
    .coef_data(coef_data), .coef_err(ce[1]), .fir_data(fd[1]), .valid(v[1]), .overflow(ov[1]));

  fir_decim_filter #(.DATA_W(16), .COEF_W(16), .NUM_TAPS(32), .DECIM(4), .SHIFT(0), .OUT_W(28)) u2 (
    .clk(clk), .rst_n(rst_n), .ready(ready && sel == 2'd2), .mix_data(mix_data), .in_ready(ir[2]),
    .flush(flush && sel == 2'd2), .coef_we(coef_we && sel == 2'd2), .coef_addr(coef_addr[4:0]),
    .coef_data(coef_data), .coef_err(ce[2]), .fir_data(fd[2]), .valid(v[2]), .overflow(ov[2]));

  fir_decim_filter #(.DATA_W(16), .COEF_W(16), .NUM_TAPS(20), .DECIM(2), .SHIFT(12), .OUT_W(28)) u3 (
    .clk(clk), .rst_n(rst_n), .ready(ready && sel == 2'd3), .mix_data(mix_data), .in_ready(ir[3]),
    .flush(flush && sel == 2'd3), .coef_we(coef_we && sel == 2'd3), .coef_addr(coef_addr[4:0]),
    .coef_data(coef_data), .coef_err(ce[3]), .fir_data(fd[3]), .valid(v[3]), .overflow(ov[3]));

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_rdy(input int inst);
    int k = 0;
    while (ir[inst] !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) begin
      checks++;
      failures++;
      $display("FAIL in_ready_timeout inst=%0d actual=0 expected=1", inst);
    end
  endtask

  // A valid output is due NUM_TAPS+3 negedges after the negedge the strobe was driven on.
  task automatic strobe_raw(input int inst, input int d, input bit exp_en, input int exp_val);
    sel      = 2'(inst);
    mix_data = 16'(d);
    ready    = 1'b1;
    if (exp_en) exp_q.push_back('{inst: inst, data: exp_val, cyc: cyc + ntaps[inst] + 3});
    @(negedge clk);
    ready = 1'b0;
  endtask

  task automatic strobe(input int inst, input int d, input bit exp_en, input int exp_val);
    wait_rdy(inst);
    strobe_raw(inst, d, exp_en, exp_val);
  endtask

  task automatic group4(input int inst, input int a, input int b, input int c, input int d,
                        input bit exp_en, input int exp_val);
    strobe(inst, a, 1'b0, 0);
    strobe(inst, b, 1'b0, 0);
    strobe(inst, c, 1'b0, 0);
    strobe(inst, d, exp_en, exp_val);
  endtask

  task automatic wcoef(input int inst, input int addr, input int data);
    sel       = 2'(inst);
    coef_we   = 1'b1;
    coef_addr = 6'(addr);
    coef_data = 16'(data);
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  task automatic flush_pulse(input int inst);
    sel   = 2'(inst);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      @(negedge clk);
      k++;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      if (v[i] === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_valid inst=%0d actual fir_data=%0d expected no valid", i, int'(fd[i]));
        end else begin
          e = exp_q.pop_front();
          check("valid_inst", i, e.inst);
          check("fir_data", int'(fd[i]), e.data);
          check("valid_cycle", cyc, e.cyc);
          check("in_ready_at_valid", int'(ir[i]), 1);
        end
      end
    end
  end

  initial begin
    step(3);
    check("rst_fir_data", int'(fd[0]), 0);
    check("rst_valid", int'(v[0]), 0);
    check("rst_coef_err", int'(ce[0]), 0);
    check("rst_overflow", int'(ov[0]), 0);
    check("rst_in_ready", int'(ir[0]), 1);
    rst_n = 1'b1;
    step(2);

    // Reset coefficients give a decimated pass-through.
    for (int i = 1; i <= 8; i++) begin
      strobe_raw(0, i, (i % 4) == 0, i);
      step(39);
    end

    wcoef(0, 0, 2048);
    check("coef_err_legal", int'(ce[0]), 0);
    for (int r = 0; r < 4; r++) group4(0, rnd_x[r], rnd_x[r], rnd_x[r], rnd_x[r], 1'b1, rnd_y[r]);
    drain();

    // Taps 0 and 4 at unity: a dropped sample written into history would change the second output.
    flush_pulse(0);
    wcoef(0, 0, 4096);
    wcoef(0, 4, 4096);
    group4(0, 10, 20, 30, 40, 1'b1, 40);
    step(4);
    strobe_raw(0, 99, 1'b0, 0);
    check("overflow_set", int'(ov[0]), 1);
    group4(0, 1, 2, 3, 5, 1'b1, 45);
    drain();
    check("overflow_sticky", int'(ov[0]), 1);
    flush_pulse(0);
    check("overflow_flush", int'(ov[0]), 0);
    group4(0, 6, 7, 8, 9, 1'b1, 9);

    group4(0, 1, 1, 1, 12, 1'b1, 21);
    step(2);
    wcoef(0, 0, 100);
    check("coef_err_mac", int'(ce[0]), 1);
    step(1);
    check("coef_err_pulse", int'(ce[0]), 0);
    group4(0, 0, 0, 0, 2, 1'b1, 14);
    drain();

    for (int k = 0; k < 8; k++) wcoef(1, k, k * 4096);
    for (int n = 0; n <= 8; n++) begin
      strobe_raw(1, (n == 0) ? 100 : 0, 1'b1, (n < 8) ? n * 100 : 0);
      step(11);
    end
    drain();

    for (int k = 0; k < 32; k++) wcoef(2, k, 32767);
    for (int s = 0; s < 32; s++) strobe(2, 32767, (s % 4) == 3, SMAX);
    for (int g = 0; g < 8; g++) group4(2, -32768, -32768, -32768, -32768, 1'b1, neg_exp[g]);
    drain();

    wcoef(3, 25, 1234);
    check("coef_err_addr", int'(ce[3]), 1);
    step(1);
    strobe(3, 3, 1'b0, 0);
    sel       = 2'd3;
    ready     = 1'b1;
    mix_data  = 16'sd7;
    coef_we   = 1'b1;
    coef_addr = 6'd0;
    coef_data = 16'sd8192;
    exp_q.push_back('{inst: 3, data: 14, cyc: cyc + ntaps[3] + 3});
    @(negedge clk);
    ready   = 1'b0;
    coef_we = 1'b0;
    check("coef_err_with_strobe", int'(ce[3]), 0);
    drain();
    wait_rdy(3);
    flush     = 1'b1;
    ready     = 1'b1;
    mix_data  = 16'sd50;
    @(negedge clk);
    flush = 1'b0;
    ready = 1'b0;
    check("flush_beats_ready", int'(ov[3]), 0);
    strobe(3, 4, 1'b0, 0);
    strobe(3, 6, 1'b1, 12);
    drain();

    // Reset mid-MAC: the aborted group must never produce a valid.
    wcoef(0, 0, 8192);
    group4(0, 0, 0, 0, 5, 1'b0, 0);
    step(10);
    rst_n = 1'b0;
    step(1);
    check("midrst_valid", int'(v[0]), 0);
    check("midrst_fir_data", int'(fd[0]), 0);
    check("midrst_in_ready", int'(ir[0]), 1);
    rst_n = 1'b1;
    step(40);
    group4(0, 0, 0, 0, 11, 1'b1, 11);
    drain();
    step(5);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
